// File: rtl/goomba_pkg.sv
// Shared Goomba/Mario constants: FSM state encoding, sprite sizes, screen limits.
package goomba_pkg;

  localparam int unsigned COORD_W = 10;
  localparam int unsigned SUM_W   = 11;
  localparam int unsigned CNT_W   = 8;

  // Goomba life-cycle states
  localparam logic [1:0] GST_ALIVE    = 2'd0;
  localparam logic [1:0] GST_SQUASHED = 2'd1;
  localparam logic [1:0] GST_GONE     = 2'd2;

  // Sprite boxes; right/bottom edge = origin + size (inclusive)
  localparam int unsigned GOOMBA_W_DEF = 26;
  localparam int unsigned GOOMBA_H_DEF = 27;
  localparam int unsigned MARIO_W_DEF  = 29;
  localparam int unsigned MARIO_H_DEF  = 39;

  // Visible screen limits, shared with goomba_display
  localparam int unsigned RIGHT_END  = 639;
  localparam int unsigned BOTTOM_END = 479;

endpackage

// File: rtl/aabb_overlap.sv
// Combinational axis-aligned box overlap test with inclusive edges.
// Ports:
//   a_left/a_top  in  box A origin
//   b_left/b_top  in  box B origin
//   overlap_c     out 1 when the boxes share at least one pixel
module aabb_overlap
  import goomba_pkg::*;
#(
  parameter int unsigned A_W = GOOMBA_W_DEF,
  parameter int unsigned A_H = GOOMBA_H_DEF,
  parameter int unsigned B_W = MARIO_W_DEF,
  parameter int unsigned B_H = MARIO_H_DEF
) (
  input  logic [COORD_W-1:0] a_left,
  input  logic [COORD_W-1:0] a_top,
  input  logic [COORD_W-1:0] b_left,
  input  logic [COORD_W-1:0] b_top,
  output logic               overlap_c
);

  logic [SUM_W-1:0] a_right;
  logic [SUM_W-1:0] a_bottom;
  logic [SUM_W-1:0] b_right;
  logic [SUM_W-1:0] b_bottom;

  // 11-bit sums so a 10-bit edge plus size never wraps
  always_comb begin
    a_right   = SUM_W'(a_left) + SUM_W'(A_W);
    a_bottom  = SUM_W'(a_top)  + SUM_W'(A_H);
    b_right   = SUM_W'(b_left) + SUM_W'(B_W);
    b_bottom  = SUM_W'(b_top)  + SUM_W'(B_H);
    overlap_c = (SUM_W'(b_left) <= a_right)  && (SUM_W'(a_left) <= b_right) &&
                (SUM_W'(b_top)  <= a_bottom) && (SUM_W'(a_top)  <= b_bottom);
  end

endmodule

// File: rtl/goomba_collision_ctrl.sv
// Per-frame Mario/Goomba collision classifier and Goomba life cycle
// (ALIVE -> SQUASHED -> GONE -> respawn).
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   frame_tick        one-cycle pulse per frame; all evaluation happens here
//   mario_left/top    Mario box origin; mario_falling = moving downward
//   goomba_left/top   Goomba box origin from goomba_display
//   goomba_visible    0 while GONE
//   goomba_squashed   1 while SQUASHED
//   goomba_freeze     1 unless ALIVE
//   goomba_respawn    1-cycle pulse on return to ALIVE
//   stomp_pulse       1-cycle pulse on a stomp (with bounce_req, score_add)
//   mario_hit_pulse   1-cycle pulse on a side hit
//   score_add         STOMP_SCORE during stomp_pulse, else 0
module goomba_collision_ctrl
  import goomba_pkg::*;
#(
  parameter int unsigned GOOMBA_W       = GOOMBA_W_DEF,
  parameter int unsigned GOOMBA_H       = GOOMBA_H_DEF,
  parameter int unsigned MARIO_W        = MARIO_W_DEF,
  parameter int unsigned MARIO_H        = MARIO_H_DEF,
  parameter int unsigned STOMP_MARGIN   = 8,
  parameter int unsigned SQUASH_FRAMES  = 30,
  parameter int unsigned RESPAWN_FRAMES = 120,
  parameter int unsigned INVULN_FRAMES  = 60,
  parameter int unsigned STOMP_SCORE    = 100
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic [COORD_W-1:0] mario_left,
  input  logic [COORD_W-1:0] mario_top,
  input  logic               mario_falling,
  input  logic [COORD_W-1:0] goomba_left,
  input  logic [COORD_W-1:0] goomba_top,
  output logic               goomba_visible,
  output logic               goomba_squashed,
  output logic               goomba_freeze,
  output logic               goomba_respawn,
  output logic               stomp_pulse,
  output logic               bounce_req,
  output logic               mario_hit_pulse,
  output logic [7:0]         score_add
);

  logic [1:0]       state_q,  state_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [CNT_W-1:0] invuln_q, invuln_d;
  logic             visible_q,  visible_d;
  logic             squashed_q, squashed_d;
  logic             freeze_q,   freeze_d;
  logic             respawn_q,  respawn_d;
  logic             stomp_q,    stomp_d;
  logic             hit_q,      hit_d;
  logic [7:0]       score_q,    score_d;

  logic             overlap_c;
  logic             stomp_zone_c;
  logic [SUM_W-1:0] m_bottom_c;
  logic [SUM_W-1:0] stomp_lim_c;

  aabb_overlap #(
    .A_W (GOOMBA_W),
    .A_H (GOOMBA_H),
    .B_W (MARIO_W),
    .B_H (MARIO_H)
  ) u_aabb (
    .a_left    (goomba_left),
    .a_top     (goomba_top),
    .b_left    (mario_left),
    .b_top     (mario_top),
    .overlap_c (overlap_c)
  );

  // Mario's feet must land within the top STOMP_MARGIN rows of the Goomba
  always_comb begin
    m_bottom_c   = SUM_W'(mario_top)  + SUM_W'(MARIO_H);
    stomp_lim_c  = SUM_W'(goomba_top) + SUM_W'(STOMP_MARGIN);
    stomp_zone_c = (m_bottom_c <= stomp_lim_c);
  end

  // Next-state, counters and output decode; everything holds outside frame_tick
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    invuln_d  = invuln_q;
    stomp_d   = 1'b0;
    hit_d     = 1'b0;
    respawn_d = 1'b0;
    if (frame_tick) begin
      invuln_d = (invuln_q == '0) ? '0 : invuln_q - CNT_W'(1);
      case (state_q)
        GST_ALIVE: begin
          if (overlap_c && mario_falling && stomp_zone_c) begin
            stomp_d = 1'b1;
            state_d = GST_SQUASHED;
            cnt_d   = CNT_W'(SQUASH_FRAMES - 1);
          end else if (overlap_c && (invuln_q == '0)) begin
            hit_d    = 1'b1;
            invuln_d = CNT_W'(INVULN_FRAMES);
          end
        end
        GST_SQUASHED: begin
          if (cnt_q == '0) begin
            state_d = GST_GONE;
            cnt_d   = CNT_W'(RESPAWN_FRAMES - 1);
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        GST_GONE: begin
          if (cnt_q == '0) begin
            state_d   = GST_ALIVE;
            respawn_d = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_d = GST_ALIVE;
          cnt_d   = '0;
        end
      endcase
    end
    visible_d  = (state_d != GST_GONE);
    squashed_d = (state_d == GST_SQUASHED);
    freeze_d   = (state_d != GST_ALIVE);
    score_d    = stomp_d ? 8'(STOMP_SCORE) : 8'd0;
  end

  // State, counter and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= GST_ALIVE;
      cnt_q      <= '0;
      invuln_q   <= '0;
      visible_q  <= 1'b1;
      squashed_q <= 1'b0;
      freeze_q   <= 1'b0;
      respawn_q  <= 1'b0;
      stomp_q    <= 1'b0;
      hit_q      <= 1'b0;
      score_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      invuln_q   <= invuln_d;
      visible_q  <= visible_d;
      squashed_q <= squashed_d;
      freeze_q   <= freeze_d;
      respawn_q  <= respawn_d;
      stomp_q    <= stomp_d;
      hit_q      <= hit_d;
      score_q    <= score_d;
    end
  end

  assign goomba_visible  = visible_q;
  assign goomba_squashed = squashed_q;
  assign goomba_freeze   = freeze_q;
  assign goomba_respawn  = respawn_q;
  assign stomp_pulse     = stomp_q;
  assign bounce_req      = stomp_q;
  assign mario_hit_pulse = hit_q;
  assign score_add       = score_q;

endmodule

// File: tb/tb_goomba_collision_ctrl.sv
// Directed bench for goomba_collision_ctrl with hand-computed expectations.
// Box math used below: goomba (100,200) -> right 126, bottom 227, stomp limit 208;
// Mario bottom = top + 39, so mario_top 169 -> bottom 208 (stomp), 170 -> 209 (side).
module tb_goomba_collision_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_tick;
  logic [9:0] mario_left;
  logic [9:0] mario_top;
  logic       mario_falling;
  logic [9:0] goomba_left;
  logic [9:0] goomba_top;
  logic       goomba_visible;
  logic       goomba_squashed;
  logic       goomba_freeze;
  logic       goomba_respawn;
  logic       stomp_pulse;
  logic       bounce_req;
  logic       mario_hit_pulse;
  logic [7:0] score_add;

  int total = 0;
  int bad   = 0;

  goomba_collision_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .frame_tick      (frame_tick),
    .mario_left      (mario_left),
    .mario_top       (mario_top),
    .mario_falling   (mario_falling),
    .goomba_left     (goomba_left),
    .goomba_top      (goomba_top),
    .goomba_visible  (goomba_visible),
    .goomba_squashed (goomba_squashed),
    .goomba_freeze   (goomba_freeze),
    .goomba_respawn  (goomba_respawn),
    .stomp_pulse     (stomp_pulse),
    .bounce_req      (bounce_req),
    .mario_hit_pulse (mario_hit_pulse),
    .score_add       (score_add)
  );

  always #5 clk = ~clk;

  // One frame_tick cycle; outputs sampled 1 time unit after the edge
  task automatic tick();
    frame_tick = 1'b1;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) idle();
    rst = 1'b0;
  endtask

  task automatic place(input int ml, input int mt, input logic fall);
    goomba_left   = 10'd100;
    goomba_top    = 10'd200;
    mario_left    = 10'(ml);
    mario_top     = 10'(mt);
    mario_falling = fall;
  endtask

  task automatic test_reset();
    logic [11:0] got;
    logic [11:0] exp;
    place(400, 0, 1'b0);
    do_reset(2);
    got = {goomba_visible, goomba_squashed, goomba_freeze, goomba_respawn,
           stomp_pulse, bounce_req, mario_hit_pulse, 1'b0, score_add[3:0]};
    exp = 12'b1000_0000_0000;
    total++;
    if (got !== exp || score_add !== 8'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%b score=%0d exp=%b score=0", got, score_add, exp);
    end
  endtask

  task automatic test_stomp();
    int errs;
    do_reset(1);
    place(100, 169, 1'b1);
    tick();
    total++;
    if (stomp_pulse !== 1'b1 || bounce_req !== 1'b1 || score_add !== 8'd100 || mario_hit_pulse !== 1'b0) begin
      bad++;
      $display("FAIL stomp_pulse got stomp=%b bounce=%b score=%0d hit=%b exp 1 1 100 0",
               stomp_pulse, bounce_req, score_add, mario_hit_pulse);
    end
    total++;
    if (goomba_squashed !== 1'b1 || goomba_freeze !== 1'b1 || goomba_visible !== 1'b1) begin
      bad++;
      $display("FAIL stomp_enter_squash got sq=%b fr=%b vis=%b exp 1 1 1",
               goomba_squashed, goomba_freeze, goomba_visible);
    end
    idle();
    total++;
    if (stomp_pulse !== 1'b0 || bounce_req !== 1'b0 || score_add !== 8'd0) begin
      bad++;
      $display("FAIL stomp_one_cycle got stomp=%b bounce=%b score=%0d exp 0 0 0",
               stomp_pulse, bounce_req, score_add);
    end
    // 29 further ticks stay squashed, no pulses despite held overlap
    errs = 0;
    for (int i = 0; i < 29; i++) begin
      tick();
      if (goomba_squashed !== 1'b1 || goomba_freeze !== 1'b1 || stomp_pulse !== 1'b0 || mario_hit_pulse !== 1'b0)
        errs++;
    end
    total++;
    if (errs !== 0) begin
      bad++;
      $display("FAIL squash_hold got %0d bad ticks exp 0", errs);
    end
    tick();
    total++;
    if (goomba_squashed !== 1'b0 || goomba_visible !== 1'b0 || goomba_freeze !== 1'b1) begin
      bad++;
      $display("FAIL squash_to_gone got sq=%b vis=%b fr=%b exp 0 0 1",
               goomba_squashed, goomba_visible, goomba_freeze);
    end
    errs = 0;
    for (int i = 0; i < 119; i++) begin
      tick();
      if (goomba_visible !== 1'b0 || goomba_respawn !== 1'b0 || stomp_pulse !== 1'b0 || mario_hit_pulse !== 1'b0)
        errs++;
    end
    total++;
    if (errs !== 0) begin
      bad++;
      $display("FAIL gone_hold got %0d bad ticks exp 0", errs);
    end
    tick();
    total++;
    if (goomba_respawn !== 1'b1 || goomba_visible !== 1'b1 || goomba_freeze !== 1'b0 || stomp_pulse !== 1'b0) begin
      bad++;
      $display("FAIL respawn got resp=%b vis=%b fr=%b stomp=%b exp 1 1 0 0",
               goomba_respawn, goomba_visible, goomba_freeze, stomp_pulse);
    end
    idle();
    total++;
    if (goomba_respawn !== 1'b0) begin
      bad++;
      $display("FAIL respawn_one_cycle got %b exp 0", goomba_respawn);
    end
    tick();
    total++;
    if (stomp_pulse !== 1'b1) begin
      bad++;
      $display("FAIL stomp_after_respawn got %b exp 1", stomp_pulse);
    end
  endtask

  task automatic test_side_hit();
    int errs;
    do_reset(1);
    place(80, 200, 1'b0);
    tick();
    total++;
    if (mario_hit_pulse !== 1'b1 || stomp_pulse !== 1'b0) begin
      bad++;
      $display("FAIL side_hit got hit=%b stomp=%b exp 1 0", mario_hit_pulse, stomp_pulse);
    end
    idle();
    total++;
    if (mario_hit_pulse !== 1'b0) begin
      bad++;
      $display("FAIL side_hit_one_cycle got %b exp 0", mario_hit_pulse);
    end
    errs = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (mario_hit_pulse !== 1'b0) errs++;
    end
    total++;
    if (errs !== 0) begin
      bad++;
      $display("FAIL invuln_window got %0d hits exp 0", errs);
    end
    tick();
    total++;
    if (mario_hit_pulse !== 1'b1) begin
      bad++;
      $display("FAIL invuln_expire got %b exp 1", mario_hit_pulse);
    end
    // Reset clears invulnerability: immediate hit afterwards
    tick();
    do_reset(1);
    tick();
    total++;
    if (mario_hit_pulse !== 1'b1) begin
      bad++;
      $display("FAIL reset_clears_invuln got %b exp 1", mario_hit_pulse);
    end
  endtask

  task automatic test_boundary();
    do_reset(1);
    place(127, 200, 1'b0);
    tick();
    total++;
    if (mario_hit_pulse !== 1'b0) begin
      bad++;
      $display("FAIL edge_127_no_hit got %b exp 0", mario_hit_pulse);
    end
    place(126, 200, 1'b0);
    tick();
    total++;
    if (mario_hit_pulse !== 1'b1) begin
      bad++;
      $display("FAIL edge_126_hit got %b exp 1", mario_hit_pulse);
    end
    do_reset(1);
    place(100, 169, 1'b1);
    tick();
    total++;
    if (stomp_pulse !== 1'b1 || mario_hit_pulse !== 1'b0) begin
      bad++;
      $display("FAIL bottom_208_stomp got stomp=%b hit=%b exp 1 0", stomp_pulse, mario_hit_pulse);
    end
    do_reset(1);
    place(100, 170, 1'b1);
    tick();
    total++;
    if (stomp_pulse !== 1'b0 || mario_hit_pulse !== 1'b1) begin
      bad++;
      $display("FAIL bottom_209_side got stomp=%b hit=%b exp 0 1", stomp_pulse, mario_hit_pulse);
    end
  endtask

  task automatic test_rising();
    do_reset(1);
    place(100, 169, 1'b0);
    tick();
    total++;
    if (stomp_pulse !== 1'b0 || mario_hit_pulse !== 1'b1 || goomba_squashed !== 1'b0) begin
      bad++;
      $display("FAIL rising_contact got stomp=%b hit=%b sq=%b exp 0 1 0",
               stomp_pulse, mario_hit_pulse, goomba_squashed);
    end
  endtask

  task automatic test_no_tick_and_reset();
    int errs;
    do_reset(1);
    place(100, 169, 1'b1);
    errs = 0;
    for (int i = 0; i < 5; i++) begin
      idle();
      if (stomp_pulse !== 1'b0 || mario_hit_pulse !== 1'b0 || goomba_squashed !== 1'b0) errs++;
    end
    total++;
    if (errs !== 0) begin
      bad++;
      $display("FAIL no_tick_no_pulse got %0d bad cycles exp 0", errs);
    end
    tick();
    tick();
    tick();
    total++;
    if (goomba_squashed !== 1'b1) begin
      bad++;
      $display("FAIL mid_squash_setup got %b exp 1", goomba_squashed);
    end
    do_reset(1);
    total++;
    if (goomba_visible !== 1'b1 || goomba_squashed !== 1'b0 || goomba_freeze !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_squash got vis=%b sq=%b fr=%b exp 1 0 0",
               goomba_visible, goomba_squashed, goomba_freeze);
    end
    tick();
    total++;
    if (stomp_pulse !== 1'b1) begin
      bad++;
      $display("FAIL alive_after_reset got %b exp 1", stomp_pulse);
    end
  endtask

  initial begin
    rst        = 1'b1;
    frame_tick = 1'b0;
    place(400, 0, 1'b0);
    test_reset();
    test_stomp();
    test_side_hit();
    test_boundary();
    test_rising();
    test_no_tick_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
